// File: rtl/platform_scheduler_if.sv
// Playfield scheduler bus: frame/scroll control in, slot table and status out.
// The scheduler takes the slave side; whoever drives frames takes master.
interface platform_scheduler_if #(
    parameter int NUM_PLAT = 16
);
    logic                  frame_clk;
    logic                  start;
    logic [7:0]            scroll_amt;
    logic [1:0]            difficulty;
    logic [NUM_PLAT*9-1:0] platX_flat;
    logic [NUM_PLAT*9-1:0] platY_flat;
    logic [NUM_PLAT*3-1:0] plat_type_flat;
    logic                  busy;
    logic                  frame_done;
    logic                  score_inc;
    logic                  overrun;

    modport master (
        output frame_clk, start, scroll_amt, difficulty,
        input  platX_flat, platY_flat, plat_type_flat,
        input  busy, frame_done, score_inc, overrun
    );

    modport slave (
        input  frame_clk, start, scroll_amt, difficulty,
        output platX_flat, platY_flat, plat_type_flat,
        output busy, frame_done, score_inc, overrun
    );
endinterface

// File: rtl/platform_scheduler.sv
// Platform slot table: init, per-frame scroll walk and respawn of slots
// that fall off the bottom, one slot per clock through a shared datapath.
module platform_scheduler #(
    parameter int          NUM_PLAT  = 16,
    parameter int          SCREEN_H  = 480,
    parameter int          SPACING   = 30,
    parameter int          MAX_X     = 448,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    platform_scheduler_if.slave bus
);
    localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_PLAT - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [15:0]     r_lfsr;
    logic            r_fs1;
    logic            r_fs2;
    logic            r_fs3;
    logic            r_pend;
    logic [7:0]      r_scroll_q;
    logic [7:0]      r_scroll_pend;
    logic [8:0]      r_x [NUM_PLAT];
    logic [8:0]      r_y [NUM_PLAT];
    logic [2:0]      r_t [NUM_PLAT];
    logic            r_busy;
    logic            r_done;
    logic            r_inc;
    logic            r_ovr;

    logic            w_edge;
    logic [15:0]     w_lfsr_nxt;
    logic [8:0]      w_xcand;
    logic [2:0]      w_type;
    logic [9:0]      w_ysum;
    logic            w_wrap;
    logic [8:0]      w_ynew;
    logic [8:0]      w_yinit;

    assign w_edge     = r_fs2 & ~r_fs3;
    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                      ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_xcand    = (r_lfsr[8:0] > 9'(MAX_X))
                      ? r_lfsr[8:0] - 9'd256
                      : r_lfsr[8:0];
    assign w_ysum     = {1'b0, r_y[r_idx]} + {2'b00, r_scroll_q};
    assign w_wrap     = (w_ysum >= 10'(SCREEN_H));
    assign w_ynew     = w_wrap ? 9'(w_ysum - 10'(SCREEN_H))
                               : w_ysum[8:0];
    assign w_yinit    = 9'(32'(r_idx) * SPACING);

    always_comb begin
        w_type = 3'd0;
        unique case (1'b1)
            (bus.difficulty == 2'd0): w_type = 3'd0;
            (bus.difficulty == 2'd1):
                w_type = (r_lfsr[12:10] == 3'd0) ? 3'd1 : 3'd0;
            default: begin
                unique case (r_lfsr[11:10])
                    2'd0:    w_type = 3'd1;
                    2'd1:    w_type = 3'd2;
                    default: w_type = 3'd0;
                endcase
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= S_INIT;
            r_idx         <= '0;
            r_lfsr        <= LFSR_SEED;
            r_fs1         <= 1'b0;
            r_fs2         <= 1'b0;
            r_fs3         <= 1'b0;
            r_pend        <= 1'b0;
            r_scroll_q    <= 8'd0;
            r_scroll_pend <= 8'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_inc         <= 1'b0;
            r_ovr         <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_t[i] <= '0;
            end
        end else begin
            r_lfsr <= w_lfsr_nxt;
            r_fs1  <= bus.frame_clk;
            r_fs2  <= r_fs1;
            r_fs3  <= r_fs2;
            r_done <= 1'b0;
            r_inc  <= 1'b0;
            if (bus.start) begin
                r_state <= S_INIT;
                r_idx   <= '0;
                r_pend  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                // Edges arriving while not idle queue one deep
                if (w_edge && r_state != S_IDLE) begin
                    if (r_pend) begin
                        r_ovr <= 1'b1;
                    end else begin
                        r_pend        <= 1'b1;
                        r_scroll_pend <= bus.scroll_amt;
                    end
                end
                unique case (r_state)
                    S_INIT: begin
                        r_x[r_idx] <= w_xcand;
                        r_y[r_idx] <= w_yinit;
                        r_t[r_idx] <= 3'd0;
                        r_idx      <= r_idx + 1'b1;
                        if (r_idx == LAST) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_busy  <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (r_pend) begin
                            r_state    <= S_SCAN;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            r_scroll_q <= r_scroll_pend;
                            r_pend     <= w_edge;
                            if (w_edge) begin
                                r_scroll_pend <= bus.scroll_amt;
                            end
                        end else if (w_edge) begin
                            r_state    <= S_SCAN;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            r_scroll_q <= bus.scroll_amt;
                        end
                    end
                    S_SCAN: begin
                        r_y[r_idx] <= w_ynew;
                        if (w_wrap) begin
                            r_x[r_idx] <= w_xcand;
                            r_t[r_idx] <= w_type;
                            r_inc      <= 1'b1;
                        end
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST) begin
                            r_state <= S_DONE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAT; g++) begin : g_flat
            assign bus.platX_flat[9*g +: 9]     = r_x[g];
            assign bus.platY_flat[9*g +: 9]     = r_y[g];
            assign bus.plat_type_flat[3*g +: 3] = r_t[g];
        end
    endgenerate

    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.score_inc  = r_inc;
    assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler with a small slot-table model.
// Cycle n counts clock edges since the frame_clk rise of each frame.
module tb_platform_scheduler;
    localparam int NP = 16;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    platform_scheduler_if #(.NUM_PLAT(NP)) bus();

    platform_scheduler #(.NUM_PLAT(NP)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int n;
    int exp_incs;
    int incs;
    bit ovr_exp = 1'b0;
    bit seen1 = 1'b0;
    bit seen2 = 1'b0;
    logic [15:0] m_l = 16'hACE1;
    logic [15:0] m_prev = 16'hACE1;
    logic [8:0] mx [NP];
    logic [8:0] my [NP];
    logic [2:0] mt [NP];

    function automatic logic [15:0] lstep(input logic [15:0] l);
        logic b;
        b = l[0];
        l = l >> 1;
        if (b) l = l ^ 16'hB400;
        return l;
    endfunction

    function automatic logic [8:0] xc(input logic [15:0] l);
        logic [8:0] v;
        v = l[8:0];
        if (v > 9'd448) v = v - 9'd256;
        return v;
    endfunction

    function automatic logic [2:0] tp(input logic [15:0] l,
                                      input logic [1:0] d);
        if (d == 2'd0) return 3'd0;
        if (d == 2'd1) return (l[12:10] == 3'd0) ? 3'd1 : 3'd0;
        case (l[11:10])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Reference LFSR; m_prev is the value the DUT used in the last cycle
    always @(posedge Clk) begin
        m_prev = m_l;
        m_l = Reset_n ? lstep(m_l) : 16'hACE1;
    end

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        n++;
    endtask

    task automatic chk_slot(input int i);
        chk("slot_x", bus.platX_flat[9*i +: 9], mx[i]);
        chk("slot_y", bus.platY_flat[9*i +: 9], my[i]);
        chk("slot_t", bus.plat_type_flat[3*i +: 3], mt[i]);
    endtask

    task automatic chk_all();
        logic [NP*9-1:0] ex;
        logic [NP*9-1:0] ey;
        logic [NP*3-1:0] et;
        for (int i = 0; i < NP; i++) begin
            ex[9*i +: 9] = mx[i];
            ey[9*i +: 9] = my[i];
            et[3*i +: 3] = mt[i];
        end
        chk("all_x", bus.platX_flat, ex);
        chk("all_y", bus.platY_flat, ey);
        chk("all_t", bus.plat_type_flat, et);
    endtask

    task automatic init_walk();
        for (int i = 0; i < NP; i++) begin
            tick();
            mx[i] = xc(m_prev);
            my[i] = 9'(i * 30);
            mt[i] = 3'd0;
            chk("init_busy", bus.busy, (i < NP - 1));
            chk_slot(i);
        end
        chk_all();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_done", bus.frame_done, 1'b0);
        end
    endtask

    task automatic model(input int i, input int sc, input logic [1:0] d);
        int ys;
        bit w;
        ys = int'(my[i]) + sc;
        w = (ys >= 480);
        if (w) begin
            my[i] = 9'(ys - 480);
            mx[i] = xc(m_prev);
            mt[i] = tp(m_prev, d);
            exp_incs++;
        end else begin
            my[i] = 9'(ys);
        end
        chk("score_inc", bus.score_inc, w);
        chk_slot(i);
        if (w && bus.plat_type_flat[3*i +: 3] == 3'd1) seen1 = 1'b1;
        if (w && bus.plat_type_flat[3*i +: 3] == 3'd2) seen2 = 1'b1;
    endtask

    // dbl: two extra edges mid-scan; st: start issued while slot 7 is due
    task automatic run_frame(input logic [7:0] s, input bit dbl,
                             input logic [7:0] s2, input logic [1:0] d,
                             input bit st);
        int last;
        bit bexp;
        bit dexp;
        last = dbl ? 44 : (st ? 11 : 26);
        bus.difficulty = d;
        bus.scroll_amt = s;
        bus.frame_clk = 1'b1;
        n = 0;
        exp_incs = 0;
        incs = 0;
        while (n < last) begin
            tick();
            if (bus.score_inc) incs++;
            if (dbl && n == 14) ovr_exp = 1'b1;
            chk("overrun", bus.overrun, ovr_exp);
            bexp = (n >= 3 && n <= 18) || (dbl && n >= 21 && n <= 36);
            chk("busy", bus.busy, bexp);
            dexp = !st && (n == 20 || (dbl && n == 38));
            chk("frame_done", bus.frame_done, dexp);
            if (n >= 4 && n <= 19 && !(st && n > 10))
                model(n - 4, int'(s), d);
            if (dbl && n >= 22 && n <= 37)
                model(n - 22, int'(s2), d);
            if (n == 4) bus.scroll_amt = s2;
            if (n == 5) bus.frame_clk = 1'b0;
            if ((dbl || st) && n == 7) bus.frame_clk = 1'b1;
            if ((dbl || st) && n == 9) bus.frame_clk = 1'b0;
            if (dbl && n == 11) begin
                bus.frame_clk = 1'b1;
                bus.scroll_amt = 8'd99;
            end
            if (dbl && n == 13) bus.frame_clk = 1'b0;
            if (st && n == 10) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        if (!st) chk("inc_count", incs, exp_incs);
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.start = 1'b0;
        bus.scroll_amt = 8'd0;
        bus.difficulty = 2'd0;
        n = 0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.frame_done, 1'b0);
        chk("rst_inc", bus.score_inc, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        chk("rst_x", bus.platX_flat, '0);
        chk("rst_y", bus.platY_flat, '0);
        chk("rst_t", bus.plat_type_flat, '0);
        Reset_n = 1'b1;
        init_walk();
        chk("x0_225", bus.platX_flat[8:0], 9'd225);
        chk("y15_450", bus.platY_flat[9*15 +: 9], 9'd450);

        run_frame(8'd20, 1'b0, 8'd20, 2'd1, 1'b0);
        chk("y15_470", bus.platY_flat[9*15 +: 9], 9'd470);
        run_frame(8'd20, 1'b0, 8'd20, 2'd1, 1'b0);
        chk("y15_wrap", bus.platY_flat[9*15 +: 9], 9'd10);
        chk("wrap_inc", incs, 1);
        run_frame(8'd0, 1'b0, 8'd0, 2'd2, 1'b0);
        chk("zero_inc", incs, 0);
        chk_all();
        run_frame(8'd20, 1'b0, 8'd20, 2'd2, 1'b0);
        chk("y14_exact", bus.platY_flat[9*14 +: 9], 9'd0);

        run_frame(8'd33, 1'b0, 8'd77, 2'd1, 1'b1);
        init_walk();
        chk("st_ovr", bus.overrun, 1'b0);

        run_frame(8'd40, 1'b1, 8'd55, 2'd2, 1'b0);
        chk_all();
        run_frame(8'd10, 1'b0, 8'd10, 2'd0, 1'b0);
        chk("ovr_sticky", bus.overrun, 1'b1);

        for (int f = 0; f < 300; f++)
            run_frame(8'd200, 1'b0, 8'd200, 2'd2, 1'b0);
        chk("seen_t1", seen1, 1'b1);
        chk("seen_t2", seen2, 1'b1);
        for (int f = 0; f < 100; f++)
            run_frame(8'd190, 1'b0, 8'd190, 2'd0, 1'b0);
        chk_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
